// File: rtl/count_scheduler_pkg.sv
// Shared types and default widths for the count scheduler.
package count_sched_pkg;
  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: on a tie, the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick
);
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end
endmodule

// File: rtl/count_scheduler.sv
// Shares an enable counter between two requesters: grants a burst of N enables,
// then confirms the counter advanced by N (mod 2^CNT_W) and pulses done.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             r,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [CNT_W-1:0] Q,
  output logic             EC,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [1:0]       done,
  output logic             err
);
  state_e           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_qstart;
  logic             r_last;
  logic             r_ec;
  logic             r_err;
  logic [1:0]       r_gnt;

  logic [1:0]       w_pick;
  logic             w_sel;
  logic [LEN_W-1:0] w_len_sel;
  logic [CNT_W-1:0] w_len_c;
  logic [CNT_W-1:0] w_qexp;

  rr_arb2 u_arb (
    .req      (req),
    .last_gnt (r_last),
    .pick     (w_pick)
  );

  assign w_sel     = w_pick[1];
  assign w_len_sel = w_sel ? len1 : len0;

  // Fit the latched length to the counter width before the modular add.
  generate
    if (LEN_W >= CNT_W) begin : g_trunc
      assign w_len_c = r_len[CNT_W-1:0];
    end else begin : g_zext
      assign w_len_c = {{(CNT_W-LEN_W){1'b0}}, r_len};
    end
  endgenerate

  assign w_qexp = r_qstart + w_len_c;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_len    <= '0;
      r_qstart <= '0;
      r_last   <= 1'b1;
      r_ec     <= 1'b0;
      r_err    <= 1'b0;
      r_gnt    <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pick) begin
            r_len    <= w_len_sel;
            r_rem    <= w_len_sel;
            r_qstart <= Q;
            r_gnt    <= w_pick;
            r_last   <= w_sel;
            // A zero-length burst goes straight to the check with no enables.
            if (w_len_sel != '0) begin
              r_state <= RUN;
              r_ec    <= 1'b1;
            end else begin
              r_state <= CHECK;
            end
          end
        end
        RUN: begin
          r_rem <= r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            r_ec    <= 1'b0;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (Q != w_qexp) r_err <= 1'b1;
          r_gnt   <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign EC   = r_ec;
  assign gnt  = r_gnt;
  assign err  = r_err;
  assign busy = (r_state != IDLE);
  assign done = (r_state == CHECK) ? r_gnt : 2'b00;
endmodule
